// File: rtl/tx_hp_pkg.sv
// Shared definitions for the TX huge-page scheduler: FSM state encoding,
// address/size constants and the completion-notification word layout.
package tx_hp_pkg;

  localparam int QW_BYTES = 8;
  localparam int PAGE_4K  = 4096;
  localparam int CHUNK_W  = 10;

  // One-hot encoding keeps the next-state decode to single-bit tests.
  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_ISSUE     = 5'b00010,
    S_WAIT_DONE = 5'b00100,
    S_NOTIFY    = 5'b01000,
    S_RELEASE   = 5'b10000
  } state_t;

  // Completion word written to the host buffer.
  typedef struct packed {
    logic [30:0] rsvd;
    logic        page_idx;  // 0 = page1, 1 = page2
    logic [31:0] qwords;    // original page length
  } notify_data_t;

  function automatic logic [63:0] pack_notify(input logic page_idx, input logic [31:0] qwords);
    notify_data_t d;
    d.rsvd     = '0;
    d.page_idx = page_idx;
    d.qwords   = qwords;
    return d;
  endfunction

endpackage

// File: rtl/tx_huge_page_sched_if.sv
// Read-request and notification handshakes between the scheduler (master)
// and the TX read-request / notification TLP engines (slave).
interface tx_huge_page_sched_if;

  logic        rd_req;
  logic [63:0] rd_req_addr;
  logic [9:0]  rd_req_qwords;
  logic        rd_req_ack;
  logic        rd_done;
  logic        notify_req;
  logic [63:0] notify_addr;
  logic [63:0] notify_data;
  logic        notify_ack;

  modport master (
    output rd_req, rd_req_addr, rd_req_qwords, notify_req, notify_addr, notify_data,
    input  rd_req_ack, rd_done, notify_ack
  );

  modport slave (
    input  rd_req, rd_req_addr, rd_req_qwords, notify_req, notify_addr, notify_data,
    output rd_req_ack, rd_done, notify_ack
  );

endinterface

// File: rtl/tx_hp_chunk_calc.sv
// Combinational chunk sizing: the largest read that fits the remaining page
// length, the engine's maximum, and the space left before the next 4KB line.
module tx_hp_chunk_calc
  import tx_hp_pkg::*;
#(
  parameter int MAX_RD_QWORDS = 64
) (
  input  logic [31:0]        i_rem,      // qwords still to read
  input  logic [8:0]         i_addr_qw,  // address bits [11:3]: qword offset inside the 4KB line
  output logic [CHUNK_W-1:0] o_chunk
);

  localparam logic [CHUNK_W-1:0] LINE_QW = CHUNK_W'(PAGE_4K / QW_BYTES);
  localparam logic [CHUNK_W-1:0] MAX_QW  = CHUNK_W'(MAX_RD_QWORDS);

  logic [CHUNK_W-1:0] w_room_qw;
  logic [CHUNK_W-1:0] w_cap;

  // Three-way minimum; room is always 1..512 because the offset is at most 511.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_room_qw = LINE_QW - {1'b0, i_addr_qw};
    w_cap     = (w_room_qw < MAX_QW) ? w_room_qw : MAX_QW;
    o_chunk   = (i_rem < {22'd0, w_cap}) ? i_rem[CHUNK_W-1:0] : w_cap;
  end

endmodule

// File: rtl/tx_huge_page_sched.sv
// TX huge-page scheduler: serves the two driver pages in strict alternation,
// reads each one out in 4KB-safe chunks (one outstanding at a time), posts a
// completion notification, then pulses the page free.
module tx_huge_page_sched
  import tx_hp_pkg::*;
#(
  parameter int MAX_RD_QWORDS = 64
) (
  input  logic        trn_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [63:0] huge_page_addr_1,
  input  logic [63:0] huge_page_addr_2,
  input  logic [31:0] huge_page_qwords_1,
  input  logic [31:0] huge_page_qwords_2,
  input  logic        huge_page_status_1,
  input  logic        huge_page_status_2,
  output logic        huge_page_free_1,
  output logic        huge_page_free_2,
  input  logic [63:0] completed_buffer_address,
  tx_huge_page_sched_if.master bus,
  output logic        busy
);

  state_t              r_state;
  logic                r_ptr;          // 0 = page1, 1 = page2
  logic [63:0]         r_cur_addr;
  logic [31:0]         r_rem;
  logic [31:0]         r_page_qwords;
  logic                r_rd_req;
  logic [63:0]         r_rd_req_addr;
  logic [CHUNK_W-1:0]  r_rd_req_qwords;
  logic                r_notify_req;
  logic [63:0]         r_notify_addr;
  logic [63:0]         r_notify_data;
  logic                r_free_1;
  logic                r_free_2;

  logic [63:0]         w_sel_addr;
  logic [31:0]         w_sel_qwords;
  logic                w_sel_status;
  logic [31:0]         w_chunk_rem;
  logic [8:0]          w_chunk_addr_qw;
  logic [CHUNK_W-1:0]  w_chunk;

  // Only the page under the pointer is ever considered, which enforces alternation.
  assign w_sel_addr   = r_ptr ? huge_page_addr_2   : huge_page_addr_1;
  assign w_sel_qwords = r_ptr ? huge_page_qwords_2 : huge_page_qwords_1;
  assign w_sel_status = r_ptr ? huge_page_status_2 : huge_page_status_1;

  // In IDLE the first chunk is sized straight from the page inputs so rd_req can
  // rise on the cycle after the unlock is seen; afterwards from the running state.
  assign w_chunk_rem     = (r_state == S_IDLE) ? w_sel_qwords     : r_rem;
  assign w_chunk_addr_qw = (r_state == S_IDLE) ? w_sel_addr[11:3] : r_cur_addr[11:3];

  tx_hp_chunk_calc #(
    .MAX_RD_QWORDS(MAX_RD_QWORDS)
  ) u_chunk_calc (
    .i_rem     (w_chunk_rem),
    .i_addr_qw (w_chunk_addr_qw),
    .o_chunk   (w_chunk)
  );

  // Page FSM with all handshake outputs registered.
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state         <= S_IDLE;
      r_ptr           <= 1'b0;
      r_cur_addr      <= '0;
      r_rem           <= '0;
      r_page_qwords   <= '0;
      r_rd_req        <= 1'b0;
      r_rd_req_addr   <= '0;
      r_rd_req_qwords <= '0;
      r_notify_req    <= 1'b0;
      r_notify_addr   <= '0;
      r_notify_data   <= '0;
      r_free_1        <= 1'b0;
      r_free_2        <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (enable && w_sel_status) begin
            r_cur_addr    <= w_sel_addr;
            r_rem         <= w_sel_qwords;
            r_page_qwords <= w_sel_qwords;
            r_notify_addr <= completed_buffer_address;
            if (w_sel_qwords == 32'd0) begin
              r_notify_req  <= 1'b1;
              r_notify_data <= pack_notify(r_ptr, w_sel_qwords);
              r_state       <= S_NOTIFY;
            end else begin
              r_rd_req        <= 1'b1;
              r_rd_req_addr   <= w_sel_addr;
              r_rd_req_qwords <= w_chunk;
              r_state         <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (bus.rd_req_ack) begin
            r_cur_addr <= r_cur_addr + 64'(r_rd_req_qwords) * 64'(QW_BYTES);
            r_rem      <= r_rem - 32'(r_rd_req_qwords);
            r_rd_req   <= 1'b0;
            r_state    <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (bus.rd_done) begin
            if (r_rem == 32'd0) begin
              r_notify_req  <= 1'b1;
              r_notify_data <= pack_notify(r_ptr, r_page_qwords);
              r_state       <= S_NOTIFY;
            end else begin
              r_rd_req        <= 1'b1;
              r_rd_req_addr   <= r_cur_addr;
              r_rd_req_qwords <= w_chunk;
              r_state         <= S_ISSUE;
            end
          end
        end

        S_NOTIFY: begin
          if (bus.notify_ack) begin
            r_notify_req <= 1'b0;
            r_free_1     <= ~r_ptr;
            r_free_2     <= r_ptr;
            r_state      <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          r_free_1 <= 1'b0;
          r_free_2 <= 1'b0;
          r_ptr    <= ~r_ptr;
          r_state  <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_req        = r_rd_req;
  assign bus.rd_req_addr   = r_rd_req_addr;
  assign bus.rd_req_qwords = r_rd_req_qwords;
  assign bus.notify_req    = r_notify_req;
  assign bus.notify_addr   = r_notify_addr;
  assign bus.notify_data   = r_notify_data;
  assign huge_page_free_1  = r_free_1;
  assign huge_page_free_2  = r_free_2;
  assign busy              = (r_state != S_IDLE);

endmodule

// File: tb/tb_tx_huge_page_sched.sv
// Bench for tx_huge_page_sched: directed scenarios plus randomized pages, each
// checked against a chunk list computed from the page address/length rules.
module tb_tx_huge_page_sched;

  localparam int MAX = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [63:0] addr_1, addr_2, cba;
  logic [31:0] qw_1, qw_2;
  logic        st_1, st_2;
  logic        free_1, free_2, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int m_ptr = 0;   // page the scheduler should serve next (0 = page1)

  always #5 clk = ~clk;

  tx_huge_page_sched_if bus();

  tx_huge_page_sched #(.MAX_RD_QWORDS(MAX)) dut (
    .trn_clk                  (clk),
    .reset                    (rst),
    .enable                   (enable),
    .huge_page_addr_1         (addr_1),
    .huge_page_addr_2         (addr_2),
    .huge_page_qwords_1       (qw_1),
    .huge_page_qwords_2       (qw_2),
    .huge_page_status_1       (st_1),
    .huge_page_status_2       (st_2),
    .huge_page_free_1         (free_1),
    .huge_page_free_2         (free_2),
    .completed_buffer_address (cba),
    .bus                      (bus),
    .busy                     (busy)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.rd_req_ack = 1'b0;
    bus.rd_done    = 1'b0;
    bus.notify_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    @(negedge clk);
  endtask

  task automatic set_page(input int idx, input logic [63:0] a, input logic [31:0] q);
    if (idx == 0) begin addr_1 = a; qw_1 = q; end
    else          begin addr_2 = a; qw_2 = q; end
  endtask

  task automatic set_status(input int idx, input logic v);
    if (idx == 0) st_1 = v; else st_2 = v;
  endtask

  // Serves the page at m_ptr to completion, acting as read engine and notify engine.
  task automatic run_page(input bit keep, input int min_stall, input int max_stall, input bit drop);
    logic [63:0] a, base, exp_na, exp_nd;
    logic [31:0] rem, qw;
    logic [63:0] exp_a[$];
    int          exp_q[$];
    int          idx, t, stall, room, c;
    idx    = m_ptr;
    base   = (idx == 0) ? addr_1 : addr_2;
    qw     = (idx == 0) ? qw_1 : qw_2;
    exp_na = cba;
    exp_nd = {31'd0, idx[0], qw};
    a = base; rem = qw;
    while (rem != 0) begin
      room = (4096 - int'(a % 64'd4096)) / 8;
      c = MAX;
      if (room < c) c = room;
      if (rem < 32'(c)) c = int'(rem);
      exp_a.push_back(a);
      exp_q.push_back(c);
      a   = a + 64'(c * 8);
      rem = rem - 32'(c);
    end

    for (int k = 0; k < exp_q.size(); k++) begin
      t = 0;
      while (bus.rd_req !== 1'b1 && t < 40) begin @(negedge clk); t++; end
      n_cmp++;
      if (bus.rd_req !== 1'b1) begin
        $display("FAIL rd_req_timeout page%0d chunk%0d: rd_req=%b, want 1", idx + 1, k, bus.rd_req);
        n_bad++;
        return;
      end
      n_cmp++;
      if (bus.rd_req_addr !== exp_a[k] || bus.rd_req_qwords !== 10'(exp_q[k]) || busy !== 1'b1) begin
        $display("FAIL rd_req_fields page%0d chunk%0d: addr=%h qw=%0d busy=%b, want addr=%h qw=%0d busy=1",
                 idx + 1, k, bus.rd_req_addr, bus.rd_req_qwords, busy, exp_a[k], exp_q[k]);
        n_bad++;
      end
      stall = $urandom_range(max_stall, min_stall);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        n_cmp++;
        if (bus.rd_req !== 1'b1 || bus.rd_req_addr !== exp_a[k] || bus.rd_req_qwords !== 10'(exp_q[k])) begin
          $display("FAIL rd_req_hold page%0d chunk%0d: req=%b addr=%h qw=%0d, want 1 %h %0d",
                   idx + 1, k, bus.rd_req, bus.rd_req_addr, bus.rd_req_qwords, exp_a[k], exp_q[k]);
          n_bad++;
        end
      end
      bus.rd_req_ack = 1'b1;
      @(negedge clk);
      bus.rd_req_ack = 1'b0;
      if (k == 0) cba = {$urandom, $urandom};   // latched address must not follow this
      if (drop && k == 0) set_status(idx, 1'b0);
      n_cmp++;
      if (bus.rd_req !== 1'b0) begin
        $display("FAIL rd_req_after_ack page%0d chunk%0d: rd_req=%b, want 0", idx + 1, k, bus.rd_req);
        n_bad++;
      end
      stall = $urandom_range(3, 0);
      for (int s = 0; s < stall; s++) begin
        // stray acks while no request/notify is pending must be ignored
        bus.rd_req_ack = 1'($urandom);
        bus.notify_ack = 1'($urandom);
        @(negedge clk);
        n_cmp++;
        if (bus.rd_req !== 1'b0 || bus.notify_req !== 1'b0) begin
          $display("FAIL wait_done_quiet page%0d chunk%0d: rd_req=%b notify_req=%b, want 0 0",
                   idx + 1, k, bus.rd_req, bus.notify_req);
          n_bad++;
        end
      end
      bus.rd_req_ack = 1'b0;
      bus.notify_ack = 1'b0;
      bus.rd_done    = 1'b1;
      @(negedge clk);
      bus.rd_done    = 1'b0;
    end

    t = 0;
    while (bus.notify_req !== 1'b1 && t < 40) begin
      n_cmp++;
      if (bus.rd_req !== 1'b0) begin
        $display("FAIL extra_rd_req page%0d: rd_req=%b, want 0", idx + 1, bus.rd_req);
        n_bad++;
      end
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (bus.notify_req !== 1'b1) begin
      $display("FAIL notify_timeout page%0d: notify_req=%b, want 1", idx + 1, bus.notify_req);
      n_bad++;
      return;
    end
    n_cmp++;
    if (bus.notify_addr !== exp_na || bus.notify_data !== exp_nd || bus.rd_req !== 1'b0) begin
      $display("FAIL notify_fields page%0d: addr=%h data=%h rd_req=%b, want addr=%h data=%h rd_req=0",
               idx + 1, bus.notify_addr, bus.notify_data, bus.rd_req, exp_na, exp_nd);
      n_bad++;
    end
    stall = $urandom_range(3, 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.notify_req !== 1'b1 || free_1 !== 1'b0 || free_2 !== 1'b0) begin
        $display("FAIL notify_hold page%0d: notify_req=%b free=%b%b, want 1 00",
                 idx + 1, bus.notify_req, free_1, free_2);
        n_bad++;
      end
    end
    bus.notify_ack = 1'b1;
    @(negedge clk);
    bus.notify_ack = 1'b0;
    n_cmp++;
    if (free_1 !== (idx == 0) || free_2 !== (idx == 1) || bus.notify_req !== 1'b0) begin
      $display("FAIL free_pulse page%0d: free_1=%b free_2=%b notify_req=%b, want %b %b 0",
               idx + 1, free_1, free_2, bus.notify_req, idx == 0, idx == 1);
      n_bad++;
    end
    if (!keep) set_status(idx, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (free_1 !== 1'b0 || free_2 !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL free_end page%0d: free=%b%b busy=%b, want 00 0", idx + 1, free_1, free_2, busy);
      n_bad++;
    end
    m_ptr = 1 - m_ptr;
  endtask

  task automatic test_reset();
    enable = 1'b0; st_1 = 1'b0; st_2 = 1'b0; cba = 64'h0;
    addr_1 = '0; addr_2 = '0; qw_1 = '0; qw_2 = '0;
    rst = 1'b1;
    bus.rd_req_ack = 1'b0; bus.rd_done = 1'b0; bus.notify_ack = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.rd_req !== 1'b0 || bus.rd_req_addr !== 64'h0 || bus.rd_req_qwords !== 10'h0 ||
        bus.notify_req !== 1'b0 || bus.notify_addr !== 64'h0 || bus.notify_data !== 64'h0 ||
        free_1 !== 1'b0 || free_2 !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL reset_outputs: req=%b addr=%h qw=%h nreq=%b naddr=%h ndata=%h free=%b%b busy=%b, want all 0",
               bus.rd_req, bus.rd_req_addr, bus.rd_req_qwords, bus.notify_req, bus.notify_addr,
               bus.notify_data, free_1, free_2, busy);
      n_bad++;
    end
    rst = 1'b0;
    m_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    cba = 64'hABCD_0000_0000_1000;
    set_page(m_ptr, 64'h1000, 32'd128);
    set_status(m_ptr, 1'b1);
    enable = 1'b1;
    run_page(1'b0, 0, 2, 1'b0);
  endtask

  task automatic test_boundary();
    set_page(m_ptr, 64'h1FF0, 32'd10);
    set_status(m_ptr, 1'b1);
    run_page(1'b0, 0, 2, 1'b0);
    // address wraps modulo 2^64 across the top 4KB line
    set_page(m_ptr, 64'hFFFF_FFFF_FFFF_FFF0, 32'd10);
    set_status(m_ptr, 1'b1);
    run_page(1'b0, 0, 2, 1'b0);
  endtask

  task automatic test_zero_and_stall();
    set_page(m_ptr, 64'h2000, 32'd0);
    set_status(m_ptr, 1'b1);
    run_page(1'b0, 0, 1, 1'b0);
    set_page(m_ptr, 64'h3F00, 32'd100);
    set_status(m_ptr, 1'b1);
    run_page(1'b0, 5, 5, 1'b0);
  endtask

  task automatic test_enable();
    enable = 1'b0;
    set_page(m_ptr, 64'h4000, 32'd70);
    set_status(m_ptr, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rd_req !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL enable_low_idle: rd_req=%b busy=%b, want 0 0", bus.rd_req, busy);
        n_bad++;
      end
    end
    enable = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_req !== 1'b1 || bus.rd_req_addr !== 64'h4000) begin
      $display("FAIL enable_latency: rd_req=%b addr=%h, want 1 0000000000004000", bus.rd_req, bus.rd_req_addr);
      n_bad++;
    end
    bus.rd_done = 1'b1;
    @(negedge clk);
    bus.rd_done = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_req !== 1'b1 || bus.rd_req_addr !== 64'h4000 || bus.rd_req_qwords !== 10'd64) begin
      $display("FAIL spurious_rd_done: rd_req=%b addr=%h qw=%0d, want 1 0000000000004000 64",
               bus.rd_req, bus.rd_req_addr, bus.rd_req_qwords);
      n_bad++;
    end
    enable = 1'b0;   // only gates leaving IDLE; this page must still finish
    run_page(1'b0, 0, 2, 1'b0);
    enable = 1'b1;
  endtask

  task automatic test_order();
    do_reset();
    set_page(1, 64'h8000, 32'd20);
    st_2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rd_req !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL out_of_order: rd_req=%b busy=%b, want 0 0", bus.rd_req, busy);
        n_bad++;
      end
    end
    set_page(0, 64'h9000, 32'd30);
    st_1 = 1'b1;
    run_page(1'b0, 0, 2, 1'b0);
    run_page(1'b0, 0, 2, 1'b0);
  endtask

  task automatic test_reset_mid();
    int t;
    do_reset();
    set_page(0, 64'hA000, 32'd200);
    st_1 = 1'b1;
    t = 0;
    while (bus.rd_req !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    n_cmp++;
    if (bus.rd_req !== 1'b1) begin
      $display("FAIL reset_mid_start: rd_req=%b, want 1", bus.rd_req);
      n_bad++;
    end
    bus.rd_req_ack = 1'b1;
    @(negedge clk);
    bus.rd_req_ack = 1'b0;
    st_1 = 1'b0;
    set_page(1, 64'hB000, 32'd8);
    st_2 = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    bus.rd_done = 1'b1;
    @(negedge clk);
    bus.rd_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (bus.rd_req !== 1'b0 || bus.notify_req !== 1'b0 || free_1 !== 1'b0 || free_2 !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL reset_abort: rd_req=%b notify_req=%b free=%b%b busy=%b, want 0 0 00 0",
                 bus.rd_req, bus.notify_req, free_1, free_2, busy);
        n_bad++;
      end
      @(negedge clk);
    end
    set_page(0, 64'hC000, 32'd5);
    st_1 = 1'b1;
    run_page(1'b0, 0, 1, 1'b0);
    run_page(1'b0, 0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_page(0, 64'hD008, 32'd40);
    set_page(1, 64'hE000, 32'd3);
    st_1 = 1'b1;
    st_2 = 1'b1;
    run_page(1'b1, 0, 1, 1'b0);
    run_page(1'b1, 0, 1, 1'b0);
    run_page(1'b0, 0, 1, 1'b0);
    run_page(1'b0, 0, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [31:0] q;
    for (int i = 0; i < 16; i++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(1, 0) == 1) a[11:0] = 12'(4096 - 8 * $urandom_range(40, 1));
      a[2:0] = 3'b000;
      q = 32'($urandom_range(300, 0));
      cba = {$urandom, $urandom};
      set_page(m_ptr, a, q);
      set_status(m_ptr, 1'b1);
      run_page(1'b0, 0, 3, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_zero_and_stall();
    test_enable();
    test_order();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
